// File: rtl/control_pkg.sv
// Shared control-unit encodings: memory, ALU and register-file operation codes
// plus the memory access timeout limit.
package control_pkg;

    typedef enum logic [2:0] {
        MEM_NOP      = 3'd0,
        MEM_READ     = 3'd1,
        MEM_WRITE    = 3'd2,
        MEM_LOAD_MAR = 3'd3,
        MEM_LOAD_PC  = 3'd4,
        MEM_INC_PC   = 3'd5
    } memory_op_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        REG_NOP   = 2'd0,
        REG_LOAD  = 2'd1,
        REG_DRIVE = 2'd2
    } reg_op_e;

    // An access with no acknowledge is abandoned after this many ACCESS cycles.
    localparam logic [3:0] MEM_TIMEOUT_CYCLES = 4'd15;

endpackage

// File: rtl/memory_unit.sv
// Memory unit: PC, MAR and MDR registers plus the FSM that runs external RAM
// request/acknowledge transactions with a sticky timeout flag.
module memory_unit
    import control_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  memory_op_e memory_op,
    input  logic       data_word_selector,
    input  logic       bus_selector,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_drive,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       mem_we,
    output logic       mem_req,
    input  logic       mem_ack,
    output logic       stall,
    output logic       mem_error,
    output logic [7:0] pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] mar_q, mar_d;
    logic [7:0] mdr_q, mdr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       fetch_q, fetch_d;
    logic       err_q, err_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= 8'h00;
            mar_q   <= 8'h00;
            mdr_q   <= 8'h00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            fetch_q <= fetch_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        fetch_d = fetch_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                case (memory_op)
                    MEM_READ, MEM_WRITE: begin
                        state_d = ACCESS;
                        addr_d  = data_word_selector ? mar_q : pc_q;
                        we_d    = (memory_op == MEM_WRITE);
                        fetch_d = ~data_word_selector;
                        cnt_d   = 4'd0;
                        if (memory_op == MEM_WRITE) begin
                            wdata_d = bus_in;
                        end
                    end
                    MEM_LOAD_MAR: mar_d = bus_in;
                    MEM_LOAD_PC:  pc_d  = bus_in;
                    MEM_INC_PC:   pc_d  = pc_q + 8'd1;
                    default: ;
                endcase
            end
            ACCESS: begin
                // A timed-out access leaves MDR and PC untouched.
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                    end
                    if (fetch_q) begin
                        pc_d = pc_q + 8'd1;
                    end
                end else if (cnt_q == MEM_TIMEOUT_CYCLES - 4'd1) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus_out   = mdr_q;
    assign bus_drive = bus_selector;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_req   = (state_q == ACCESS);
    assign stall     = (state_q != IDLE);
    assign mem_error = err_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit: fetch, waited write, PC wrap,
// timeout, asynchronous reset mid-access and op masking during an access.
module tb_memory_unit;
    import control_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    memory_op_e memory_op = MEM_NOP;
    logic       data_word_selector = 1'b0;
    logic       bus_selector = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_we;
    logic       mem_req;
    logic       mem_ack = 1'b0;
    logic       stall;
    logic       mem_error;
    logic [7:0] pc;

    int passCount = 0;
    int checkCount = 0;
    int txCount = 0;
    int reqRise = 0;

    memory_unit dut (
        .clock(clock), .reset(reset), .memory_op(memory_op),
        .data_word_selector(data_word_selector), .bus_selector(bus_selector),
        .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall(stall), .mem_error(mem_error), .pc(pc)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (mem_req === 1'b1 && mem_ack === 1'b1) txCount++;
    always @(posedge mem_req) reqRise++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doOp(input memory_op_e op, input logic [7:0] busVal);
        @(negedge clock);
        memory_op = op;
        bus_in = busVal;
        @(negedge clock);
        memory_op = MEM_NOP;
    endtask

    // Issues one READ/WRITE, acks after ackDelay ACCESS cycles (negative = never)
    // and records what the RAM port showed while the request was up.
    task automatic runAccess(input memory_op_e op, input logic sel, input logic [7:0] busVal,
                             input int ackDelay, input logic [7:0] rdata,
                             output int reqCycles, output int stallCycles,
                             output logic [7:0] addrSeen, output logic [7:0] wdataSeen,
                             output logic weSeen, output logic stable, output logic timedOut);
        reqCycles = 0; stallCycles = 0; stable = 1'b1; timedOut = 1'b1;
        addrSeen = 8'h00; wdataSeen = 8'h00; weSeen = 1'b0;
        @(negedge clock);
        memory_op = op; data_word_selector = sel; bus_in = busVal; mem_rdata = rdata; mem_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            memory_op = MEM_NOP;
            if (stall) stallCycles++;
            if (mem_req) begin
                reqCycles++;
                if (reqCycles == 1) begin
                    addrSeen = mem_addr; wdataSeen = mem_wdata; weSeen = mem_we;
                end else if (mem_addr !== addrSeen || mem_wdata !== wdataSeen || mem_we !== weSeen) begin
                    stable = 1'b0;
                end
            end
            mem_ack = (ackDelay >= 0) && mem_req && (reqCycles > ackDelay);
            if (!stall) begin
                timedOut = 1'b0;
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checkCount++; if (pc !== 8'h00) $display("[TB] FAIL reset_pc: got %h want 00", pc); else passCount++;
        checkCount++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", stall); else passCount++;
        checkCount++; if (mem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", mem_req); else passCount++;
        checkCount++; if (mem_error !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", mem_error); else passCount++;
        checkCount++; if (bus_out !== 8'h00) $display("[TB] FAIL reset_mdr: got %h want 00", bus_out); else passCount++;
        bus_selector = 1'b1;
        #1;
        checkCount++; if (bus_drive !== 1'b1) $display("[TB] FAIL bus_drive: got %b want 1", bus_drive); else passCount++;
        bus_selector = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        memory_op = MEM_LOAD_PC;
        bus_in = 8'h10;
        @(negedge clock);
        memory_op = MEM_NOP;
        checkCount++; if (pc !== 8'h10) $display("[TB] FAIL first_op_pc: got %h want 10", pc); else passCount++;
    endtask

    task automatic test_fetch();
        int rq, st; logic [7:0] a, w; logic we, stb, to;
        runAccess(MEM_READ, 1'b0, 8'h00, 0, 8'hA5, rq, st, a, w, we, stb, to);
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL fetch_done: got timeout want completion"); else passCount++;
        checkCount++; if (a !== 8'h10) $display("[TB] FAIL fetch_addr: got %h want 10", a); else passCount++;
        checkCount++; if (we !== 1'b0) $display("[TB] FAIL fetch_we: got %b want 0", we); else passCount++;
        checkCount++; if (bus_out !== 8'hA5) $display("[TB] FAIL fetch_mdr: got %h want a5", bus_out); else passCount++;
        checkCount++; if (pc !== 8'h11) $display("[TB] FAIL fetch_pc: got %h want 11", pc); else passCount++;
        checkCount++; if (st !== 2) $display("[TB] FAIL fetch_stall: got %0d want 2", st); else passCount++;
        checkCount++; if (rq !== 1) $display("[TB] FAIL fetch_req: got %0d want 1", rq); else passCount++;
    endtask

    task automatic test_write_wait();
        int rq, st; logic [7:0] a, w; logic we, stb, to;
        doOp(MEM_LOAD_MAR, 8'h80);
        runAccess(MEM_WRITE, 1'b1, 8'h3C, 4, 8'hEE, rq, st, a, w, we, stb, to);
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL write_done: got timeout want completion"); else passCount++;
        checkCount++; if (a !== 8'h80) $display("[TB] FAIL write_addr: got %h want 80", a); else passCount++;
        checkCount++; if (w !== 8'h3C) $display("[TB] FAIL write_wdata: got %h want 3c", w); else passCount++;
        checkCount++; if (we !== 1'b1) $display("[TB] FAIL write_we: got %b want 1", we); else passCount++;
        checkCount++; if (rq !== 5) $display("[TB] FAIL write_req: got %0d want 5", rq); else passCount++;
        checkCount++; if (stb !== 1'b1) $display("[TB] FAIL write_stable: got %b want 1", stb); else passCount++;
        checkCount++; if (pc !== 8'h11) $display("[TB] FAIL write_pc: got %h want 11", pc); else passCount++;
        checkCount++; if (bus_out !== 8'hA5) $display("[TB] FAIL write_mdr: got %h want a5", bus_out); else passCount++;
    endtask

    task automatic test_wrap();
        int rq, st; logic [7:0] a, w; logic we, stb, to;
        doOp(MEM_LOAD_PC, 8'hFF);
        doOp(MEM_INC_PC, 8'h00);
        checkCount++; if (pc !== 8'h00) $display("[TB] FAIL wrap_inc: got %h want 00", pc); else passCount++;
        doOp(MEM_LOAD_PC, 8'hFF);
        runAccess(MEM_READ, 1'b0, 8'h00, 0, 8'h5A, rq, st, a, w, we, stb, to);
        checkCount++; if (a !== 8'hFF) $display("[TB] FAIL wrap_addr: got %h want ff", a); else passCount++;
        checkCount++; if (pc !== 8'h00) $display("[TB] FAIL wrap_fetch: got %h want 00", pc); else passCount++;
        checkCount++; if (bus_out !== 8'h5A) $display("[TB] FAIL wrap_mdr: got %h want 5a", bus_out); else passCount++;
    endtask

    task automatic test_timeout();
        int rq, st; logic [7:0] a, w; logic we, stb, to;
        runAccess(MEM_READ, 1'b1, 8'h00, -1, 8'hEE, rq, st, a, w, we, stb, to);
        checkCount++; if (to !== 1'b0) $display("[TB] FAIL timeout_idle: got stuck want return to idle"); else passCount++;
        checkCount++; if (rq !== 15) $display("[TB] FAIL timeout_req: got %0d want 15", rq); else passCount++;
        checkCount++; if (mem_error !== 1'b1) $display("[TB] FAIL timeout_err: got %b want 1", mem_error); else passCount++;
        checkCount++; if (bus_out !== 8'h5A) $display("[TB] FAIL timeout_mdr: got %h want 5a", bus_out); else passCount++;
        checkCount++; if (pc !== 8'h00) $display("[TB] FAIL timeout_pc: got %h want 00", pc); else passCount++;
        runAccess(MEM_READ, 1'b1, 8'h00, 1, 8'h77, rq, st, a, w, we, stb, to);
        checkCount++; if (rq !== 2) $display("[TB] FAIL retry_req: got %0d want 2", rq); else passCount++;
        checkCount++; if (bus_out !== 8'h77) $display("[TB] FAIL retry_mdr: got %h want 77", bus_out); else passCount++;
        checkCount++; if (mem_error !== 1'b1) $display("[TB] FAIL sticky_err: got %b want 1", mem_error); else passCount++;
    endtask

    task automatic test_reset_mid();
        doOp(MEM_LOAD_PC, 8'h42);
        @(negedge clock);
        memory_op = MEM_READ; data_word_selector = 1'b0; mem_ack = 1'b0;
        @(negedge clock);
        memory_op = MEM_NOP;
        @(negedge clock);
        checkCount++; if (mem_req !== 1'b1) $display("[TB] FAIL mid_pre_req: got %b want 1", mem_req); else passCount++;
        reset = 1'b1;
        #1;
        checkCount++; if (mem_req !== 1'b0) $display("[TB] FAIL mid_req: got %b want 0", mem_req); else passCount++;
        checkCount++; if (stall !== 1'b0) $display("[TB] FAIL mid_stall: got %b want 0", stall); else passCount++;
        checkCount++; if (pc !== 8'h00) $display("[TB] FAIL mid_pc: got %h want 00", pc); else passCount++;
        checkCount++; if (bus_out !== 8'h00) $display("[TB] FAIL mid_mdr: got %h want 00", bus_out); else passCount++;
        checkCount++; if (mem_addr !== 8'h00) $display("[TB] FAIL mid_addr: got %h want 00", mem_addr); else passCount++;
        checkCount++; if (mem_wdata !== 8'h00) $display("[TB] FAIL mid_wdata: got %h want 00", mem_wdata); else passCount++;
        checkCount++; if (mem_we !== 1'b0) $display("[TB] FAIL mid_we: got %b want 0", mem_we); else passCount++;
        checkCount++; if (mem_error !== 1'b0) $display("[TB] FAIL mid_err: got %b want 0", mem_error); else passCount++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_op_mask();
        int cyc = 0;
        logic idleOk = 1'b1;
        logic finished = 1'b0;
        txCount = 0;
        reqRise = 0;
        @(negedge clock);
        memory_op = MEM_READ; data_word_selector = 1'b0; mem_rdata = 8'h99; mem_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (stall) begin
                memory_op = MEM_WRITE;
                bus_in = 8'hEE;
                if (mem_req) cyc++;
                mem_ack = mem_req && (cyc >= 3);
            end else begin
                memory_op = MEM_NOP;
                finished = 1'b1;
                break;
            end
        end
        mem_ack = 1'b0;
        checkCount++; if (finished !== 1'b1) $display("[TB] FAIL mask_done: got stuck want return to idle"); else passCount++;
        repeat (3) begin
            @(negedge clock);
            if (stall !== 1'b0 || mem_req !== 1'b0) idleOk = 1'b0;
        end
        checkCount++; if (txCount !== 1) $display("[TB] FAIL mask_tx: got %0d want 1", txCount); else passCount++;
        checkCount++; if (reqRise !== 1) $display("[TB] FAIL mask_req_rise: got %0d want 1", reqRise); else passCount++;
        checkCount++; if (idleOk !== 1'b1) $display("[TB] FAIL mask_idle: got %b want 1", idleOk); else passCount++;
        checkCount++; if (mem_we !== 1'b0) $display("[TB] FAIL mask_we: got %b want 0", mem_we); else passCount++;
        checkCount++; if (mem_wdata !== 8'h00) $display("[TB] FAIL mask_wdata: got %h want 00", mem_wdata); else passCount++;
        checkCount++; if (bus_out !== 8'h99) $display("[TB] FAIL mask_mdr: got %h want 99", bus_out); else passCount++;
        checkCount++; if (pc !== 8'h01) $display("[TB] FAIL mask_pc: got %h want 01", pc); else passCount++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_wait();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_op_mask();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
